// File: rtl/uart_cmd_pkg.sv
// Shared constants and FSM state encoding for the UART command parser.
package uart_cmd_pkg;

    localparam logic [7:0] HDR   = 8'h55;
    localparam logic [7:0] OP_WR = 8'hAA;
    localparam logic [7:0] OP_RD = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        LEN,
        DATA,
        CHK,
        PUSH,
        TRIG
    } state_t;

endpackage

// File: rtl/cmd_payload_buf.sv
// Payload staging buffer: MAX_LEN x 8 register file, synchronous write,
// asynchronous read, addressed by the parser's byte index.
module cmd_payload_buf #(
    parameter int MAX_LEN = 16,
    parameter int ADDR_W  = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [MAX_LEN];

    // Capture one payload byte per write strobe.
    // NOTE: storage has no reset; every entry read during PUSH was written earlier in the same frame.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames the uart_rx byte stream (0x55 | CMD | LEN | payload | CHK) into
// validated SDRAM write/read commands. Write payload is held in
// cmd_payload_buf and only pushed to the write FIFO once the frame checks out.
// Build option: define UART_CMD_CHKSUM_EN to include and verify the trailing
// XOR checksum byte; without it frames end after LEN (read) or the payload.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int MAX_LEN     = 16,
    parameter int LEN_W       = 5,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       rx_data,
    input  logic             flag_rx_end,
    input  logic             wfifo_full,
    output logic             wfifo_wr_en,
    output logic [7:0]       wfifo_wr_data,
    output logic             wr_trig,
    output logic             rd_trig,
    output logic [LEN_W-1:0] burst_len,
    output logic             busy,
    output logic             frame_err
);

    localparam int         TO_W      = $clog2(TIMEOUT_CYC);
    localparam int         BUF_AW    = $clog2(MAX_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t            state;
    state_t            state_nxt;
    logic [LEN_W-1:0]  idx;
    logic [TO_W-1:0]   to_cnt;
    logic              is_wr;
    logic              err_pend;
    logic              err_now;
    logic              buf_we;
    logic [7:0]        buf_rdata;
    logic              timed;
    logic              to_hit;
    logic              len_ok;
    logic              last_idx;
`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]        chk_acc;
`endif

    assign timed    = (state == CMD) || (state == LEN) || (state == DATA) || (state == CHK);
    assign to_hit   = timed && !flag_rx_end && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
    assign len_ok   = (rx_data != 8'h00) && (rx_data <= MAX_LEN_B);
    assign last_idx = (idx == burst_len - LEN_W'(1));
    assign busy     = (state != IDLE);

    // A byte dropped during TRIG is reported one cycle later so it never coincides with a trig.
    assign frame_err = err_now | err_pend;

    assign wfifo_wr_data = wfifo_wr_en ? buf_rdata : 8'h00;

    cmd_payload_buf #(
        .MAX_LEN (MAX_LEN),
        .ADDR_W  (BUF_AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .waddr (idx[BUF_AW-1:0]),
        .wdata (rx_data),
        .raddr (idx[BUF_AW-1:0]),
        .rdata (buf_rdata)
    );

    // Next-state decode and per-state output strobes.
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt   = state;
        err_now     = 1'b0;
        buf_we      = 1'b0;
        wfifo_wr_en = 1'b0;
        wr_trig     = 1'b0;
        rd_trig     = 1'b0;
        case (state)
            IDLE: begin
                if (flag_rx_end && rx_data == HDR) state_nxt = CMD;
            end
            CMD: begin
                if (flag_rx_end) begin
                    if (rx_data == OP_WR || rx_data == OP_RD) begin
                        state_nxt = LEN;
                    end else begin
                        err_now   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end
            LEN: begin
                if (flag_rx_end) begin
                    if (!len_ok) begin
                        err_now   = 1'b1;
                        state_nxt = IDLE;
                    end else if (is_wr) begin
                        state_nxt = DATA;
                    end else begin
`ifdef UART_CMD_CHKSUM_EN
                        state_nxt = CHK;
`else
                        state_nxt = TRIG;
`endif
                    end
                end
            end
            DATA: begin
                if (flag_rx_end) begin
                    buf_we = 1'b1;
                    if (last_idx) begin
`ifdef UART_CMD_CHKSUM_EN
                        state_nxt = CHK;
`else
                        state_nxt = PUSH;
`endif
                    end
                end
            end
`ifdef UART_CMD_CHKSUM_EN
            CHK: begin
                if (flag_rx_end) begin
                    if (rx_data != chk_acc) begin
                        err_now   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = is_wr ? PUSH : TRIG;
                    end
                end
            end
`endif
            PUSH: begin
                if (!wfifo_full) begin
                    wfifo_wr_en = 1'b1;
                    if (last_idx) state_nxt = TRIG;
                end
                if (flag_rx_end) err_now = 1'b1;
            end
            TRIG: begin
                wr_trig   = is_wr;
                rd_trig   = !is_wr;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (to_hit) begin
            err_now   = 1'b1;
            state_nxt = IDLE;
        end
    end

    // State, byte index, inter-byte timeout, command type and latched length.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            to_cnt    <= '0;
            is_wr     <= 1'b0;
            err_pend  <= 1'b0;
            burst_len <= '0;
        end else begin
            state    <= state_nxt;
            err_pend <= (state == TRIG) && flag_rx_end;
            to_cnt   <= (timed && !flag_rx_end) ? to_cnt + TO_W'(1) : '0;

            if (state_nxt != state) begin
                idx <= '0;
            end else if (buf_we || wfifo_wr_en) begin
                idx <= idx + LEN_W'(1);
            end

            if (state == CMD && flag_rx_end) begin
                is_wr <= (rx_data == OP_WR);
            end

            if (state == LEN && flag_rx_end && len_ok) begin
                burst_len <= rx_data[LEN_W-1:0];
            end
        end
    end

`ifdef UART_CMD_CHKSUM_EN
    // Running XOR over CMD, LEN and payload bytes of the open frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            chk_acc <= 8'h00;
        end else if (flag_rx_end) begin
            if (state == CMD) begin
                chk_acc <= rx_data;
            end else if (state == LEN || state == DATA) begin
                chk_acc <= chk_acc ^ rx_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed self-checking bench for uart_cmd_parser. Adapts frame layout to
// whether UART_CMD_CHKSUM_EN is defined.
module tb_uart_cmd_parser;

    localparam int T = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       flag_rx_end = 1'b0;
    logic       wfifo_full = 1'b0;
    logic       wfifo_wr_en;
    logic [7:0] wfifo_wr_data;
    logic       wr_trig;
    logic       rd_trig;
    logic [4:0] burst_len;
    logic       busy;
    logic       frame_err;

    uart_cmd_parser #(
        .MAX_LEN     (16),
        .LEN_W       (5),
        .TIMEOUT_CYC (T)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .flag_rx_end   (flag_rx_end),
        .wfifo_full    (wfifo_full),
        .wfifo_wr_en   (wfifo_wr_en),
        .wfifo_wr_data (wfifo_wr_data),
        .wr_trig       (wr_trig),
        .rd_trig       (rd_trig),
        .burst_len     (burst_len),
        .busy          (busy),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         push_cyc[$];
    logic [7:0] push_dat[$];
    int         wtrig_cyc[$];
    int         rtrig_cyc[$];
    int         err_cyc[$];
    int         overlap = 0;

    always @(negedge clk) begin
        if (wfifo_wr_en) begin
            push_cyc.push_back(cyc);
            push_dat.push_back(wfifo_wr_data);
        end
        if (wr_trig) wtrig_cyc.push_back(cyc);
        if (rd_trig) rtrig_cyc.push_back(cyc);
        if (frame_err) err_cyc.push_back(cyc);
        if (frame_err && (wr_trig || rd_trig)) overlap++;
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int last_strobe = 0;

    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        flag_rx_end = 1'b1;
        last_strobe = cyc;
        tick();
        flag_rx_end = 1'b0;
        rx_data     = 8'h00;
    endtask

    logic [7:0] pl [16];

    function automatic logic [7:0] xsum(input logic [7:0] cmd, input logic [7:0] len, input int n);
        logic [7:0] x;
        x = cmd ^ len;
        for (int i = 0; i < n; i++) x = x ^ pl[i];
        return x;
    endfunction

    task automatic send_frame(input logic [7:0] cmd, input logic [7:0] len, input int n, input bit bad);
        send_byte(8'h55);
        send_byte(cmd);
        send_byte(len);
        for (int i = 0; i < n; i++) send_byte(pl[i]);
`ifdef UART_CMD_CHKSUM_EN
        send_byte(bad ? ~xsum(cmd, len, n) : xsum(cmd, len, n));
`endif
    endtask

    task automatic clear_logs();
        push_cyc.delete();
        push_dat.delete();
        wtrig_cyc.delete();
        rtrig_cyc.delete();
        err_cyc.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int s;

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_wr_en", wfifo_wr_en, 0);
        check("rst_wr_data", wfifo_wr_data, 0);
        check("rst_wr_trig", wr_trig, 0);
        check("rst_rd_trig", rd_trig, 0);
        check("rst_burst_len", burst_len, 0);
        check("rst_frame_err", frame_err, 0);
        rst = 1'b0;
        repeat (2) tick();

        // Write 3 bytes: pushes on 3 consecutive clocks, wr_trig right after
        clear_logs();
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        send_frame(8'hAA, 8'd3, 3, 1'b0);
        c = last_strobe;
        wait_idle("wr3", 20);
        check("wr3_npush", push_cyc.size(), 3);
        if (push_cyc.size() == 3) begin
            check("wr3_d0", push_dat[0], 8'h11);
            check("wr3_d1", push_dat[1], 8'h22);
            check("wr3_d2", push_dat[2], 8'h33);
            check("wr3_first_cyc", push_cyc[0], c + 1);
            check("wr3_last_cyc", push_cyc[2], c + 3);
        end
        check("wr3_ntrig", wtrig_cyc.size(), 1);
        if (wtrig_cyc.size() == 1) check("wr3_trig_cyc", wtrig_cyc[0], c + 4);
        check("wr3_len", burst_len, 3);
        check("wr3_err", err_cyc.size(), 0);
        check("wr3_rtrig", rtrig_cyc.size(), 0);

        // Read LEN=8: rd_trig one clock after the last frame byte, no pushes
        clear_logs();
        send_frame(8'hA5, 8'd8, 0, 1'b0);
        c = last_strobe;
        wait_idle("rd8", 20);
        check("rd8_ntrig", rtrig_cyc.size(), 1);
        if (rtrig_cyc.size() == 1) check("rd8_trig_cyc", rtrig_cyc[0], c + 1);
        check("rd8_len", burst_len, 8);
        check("rd8_npush", push_cyc.size(), 0);
        check("rd8_wtrig", wtrig_cyc.size(), 0);

`ifdef UART_CMD_CHKSUM_EN
        // Bad checksum: reject at CHK, nothing pushed or triggered
        clear_logs();
        pl[0] = 8'h01; pl[1] = 8'h02;
        send_frame(8'hAA, 8'd2, 2, 1'b1);
        c = last_strobe;
        repeat (8) tick();
        check("badchk_nerr", err_cyc.size(), 1);
        if (err_cyc.size() == 1) check("badchk_err_cyc", err_cyc[0], c);
        check("badchk_npush", push_cyc.size(), 0);
        check("badchk_wtrig", wtrig_cyc.size(), 0);
        check("badchk_busy", busy, 0);
        check("badchk_len", burst_len, 2);
`endif

        // LEN=0, LEN=17 and a bad CMD are rejected at the offending byte
        clear_logs();
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h00);
        s = last_strobe;
        tick();
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h11);
        c = last_strobe;
        tick();
        check("len_bad_err", err_cyc.size(), 2);
        if (err_cyc.size() == 2) begin
            check("len0_err_cyc", err_cyc[0], s);
            check("len17_err_cyc", err_cyc[1], c);
        end
`ifdef UART_CMD_CHKSUM_EN
        check("len_bad_keep", burst_len, 2);
`else
        check("len_bad_keep", burst_len, 8);
`endif
        clear_logs();
        send_byte(8'h55); send_byte(8'h12);
        c = last_strobe;
        tick();
        check("cmd_bad_nerr", err_cyc.size(), 1);
        if (err_cyc.size() == 1) check("cmd_bad_err_cyc", err_cyc[0], c);
        check("cmd_bad_busy", busy, 0);

        // LEN=MAX_LEN boundary is accepted
        clear_logs();
        send_frame(8'hA5, 8'd16, 0, 1'b0);
        wait_idle("rd16", 20);
        check("rd16_ntrig", rtrig_cyc.size(), 1);
        check("rd16_len", burst_len, 16);
        check("rd16_err", err_cyc.size(), 0);

        // Stall after LEN: timeout aborts exactly T clocks after the last strobe
        clear_logs();
        send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02);
        s = last_strobe;
        repeat (T + 10) tick();
        check("to_nerr", err_cyc.size(), 1);
        if (err_cyc.size() == 1) check("to_err_cyc", err_cyc[0], s + T);
        check("to_busy", busy, 0);
        check("to_npush", push_cyc.size(), 0);
        clear_logs();
        send_frame(8'hA5, 8'd4, 0, 1'b0);
        wait_idle("to_next", 20);
        check("to_next_trig", rtrig_cyc.size(), 1);
        check("to_next_len", burst_len, 4);

        // FIFO full for 5 clocks mid-PUSH, plus a stray byte dropped during PUSH
        clear_logs();
        pl[0] = 8'hA1; pl[1] = 8'hB2; pl[2] = 8'hC3; pl[3] = 8'hD4;
        send_frame(8'hAA, 8'd4, 4, 1'b0);
        c = last_strobe;
        tick();
        wfifo_full = 1'b1;
        send_byte(8'h55);
        repeat (4) tick();
        wfifo_full = 1'b0;
        wait_idle("stall", 20);
        check("stall_npush", push_cyc.size(), 4);
        if (push_cyc.size() == 4) begin
            check("stall_d0", push_dat[0], 8'hA1);
            check("stall_d1", push_dat[1], 8'hB2);
            check("stall_d2", push_dat[2], 8'hC3);
            check("stall_d3", push_dat[3], 8'hD4);
            check("stall_cyc0", push_cyc[0], c + 1);
            check("stall_cyc1", push_cyc[1], c + 7);
            check("stall_cyc3", push_cyc[3], c + 9);
        end
        check("stall_ntrig", wtrig_cyc.size(), 1);
        if (wtrig_cyc.size() == 1) check("stall_trig_cyc", wtrig_cyc[0], c + 10);
        check("stall_nerr", err_cyc.size(), 1);
        if (err_cyc.size() == 1) check("stall_err_cyc", err_cyc[0], c + 2);

        // Byte arriving during TRIG is dropped and flagged the cycle after the trig
        clear_logs();
        send_frame(8'hA5, 8'd2, 0, 1'b0);
        c = last_strobe;
        send_byte(8'h00);
        repeat (3) tick();
        check("trigdrop_ntrig", rtrig_cyc.size(), 1);
        if (rtrig_cyc.size() == 1) check("trigdrop_trig_cyc", rtrig_cyc[0], c + 1);
        check("trigdrop_nerr", err_cyc.size(), 1);
        if (err_cyc.size() == 1) check("trigdrop_err_cyc", err_cyc[0], c + 2);

        // Reset during PUSH: back to IDLE, no pushes, no wr_trig afterwards
        clear_logs();
        wfifo_full = 1'b1;
        pl[0] = 8'h5A; pl[1] = 8'h6B; pl[2] = 8'h7C;
        send_frame(8'hAA, 8'd3, 3, 1'b0);
        repeat (2) tick();
        check("rstpush_busy_before", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wfifo_full = 1'b0;
        repeat (10) tick();
        check("rstpush_busy", busy, 0);
        check("rstpush_npush", push_cyc.size(), 0);
        check("rstpush_wtrig", wtrig_cyc.size(), 0);

        check("err_trig_overlap", overlap, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
